// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, ALU opcodes and command codes for muldiv_seq.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIXUP,
    DONE
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_NEG  = 3'b110;

  localparam logic CMD_MUL = 1'b0;
  localparam logic CMD_DIV = 1'b1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitude extraction and signed result correction.
// Only built with `MULDIV_SIGNED_EN defined.
`ifdef MULDIV_SIGNED_EN
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input  logic             sgn,
  input  logic [WIDTH:0]   op_a,
  input  logic [WIDTH:0]   op_b,
  output logic             neg_a,
  output logic             neg_b,
  output logic [WIDTH:0]   mag_a,
  output logic [WIDTH:0]   mag_b,
  input  logic             cmd,
  input  logic             sa,
  input  logic             sb,
  input  logic [WIDTH:0]   hi_in,
  input  logic [WIDTH:0]   lo_in,
  output logic [WIDTH:0]   hi_out,
  output logic [WIDTH:0]   lo_out
);

  logic [2*WIDTH+1:0] prod_neg;

  always_comb begin
    neg_a    = sgn & op_a[WIDTH];
    neg_b    = sgn & op_b[WIDTH];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    prod_neg = -{hi_in, lo_in};
    if (cmd == CMD_MUL) begin
      {hi_out, lo_out} = (sa ^ sb) ? prod_neg : {hi_in, lo_in};
    end else begin
      // quotient takes the sign of a^b, remainder the sign of the dividend
      lo_out = (sa ^ sb) ? -lo_in : lo_in;
      hi_out = sa ? -hi_in : hi_in;
    end
  end

endmodule
`endif

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply / restoring divide using the shared ALU.
// Signed operation (extra FIXUP state) is built only with `MULDIV_SIGNED_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmd,
  input  logic             sgn,
  input  logic [WIDTH:0]   op_a,
  input  logic [WIDTH:0]   op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   res_hi,
  output logic [WIDTH:0]   res_lo,
  output logic             div_zero,
  output logic [WIDTH:0]   alu_a,
  output logic [WIDTH:0]   alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_s_inm,
  input  logic [WIDTH:0]   alu_y,
  input  logic             alu_carry
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic               cmd_q, cmd_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH:0]     lo_q, lo_d;
  logic [WIDTH:0]     opd_q, opd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH:0]     res_hi_q, res_hi_d;
  logic [WIDTH:0]     res_lo_q, res_lo_d;

  logic [WIDTH:0]     mag_a, mag_b;
  logic               cout, rmsb, sub_ok;
  logic [WIDTH:0]     rsh, mul_hi, mul_lo, div_hi, div_lo;

`ifdef MULDIV_SIGNED_EN
  logic               sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;
  logic               neg_a, neg_b;
  logic [WIDTH:0]     fix_hi, fix_lo;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .sgn    (sgn),
    .op_a   (op_a),
    .op_b   (op_b),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .cmd    (cmd_q),
    .sa     (sa_q),
    .sb     (sb_q),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign mag_a      = op_a;
  assign mag_b      = op_b;
`endif

  always_comb begin
    cout   = (alu_y < hi_q);
    mul_hi = lo_q[0] ? {cout, alu_y[WIDTH:1]}    : {1'b0, hi_q[WIDTH:1]};
    mul_lo = lo_q[0] ? {alu_y[0], lo_q[WIDTH:1]} : {hi_q[0], lo_q[WIDTH:1]};
    rmsb   = hi_q[WIDTH];
    rsh    = {hi_q[WIDTH-1:0], lo_q[WIDTH]};
    sub_ok = rmsb | ~alu_carry;
    div_hi = sub_ok ? alu_y : rsh;
    div_lo = {lo_q[WIDTH-1:0], sub_ok};
  end

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_PASS;
    alu_s_inm = 1'b0;
    if (state_q == ITER) begin
      alu_b  = opd_q;
      alu_a  = (cmd_q == CMD_MUL) ? hi_q : rsh;
      alu_op = (cmd_q == CMD_MUL) ? ALU_ADD : ALU_SUB;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opd_d      = opd_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
`ifdef MULDIV_SIGNED_EN
    sgn_d      = sgn_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          cmd_d   = cmd;
          // hi keeps the raw dividend until LOAD so divide-by-zero can return it
          hi_d    = op_a;
          lo_d    = (cmd == CMD_MUL) ? mag_b : mag_a;
          opd_d   = (cmd == CMD_MUL) ? mag_a : mag_b;
`ifdef MULDIV_SIGNED_EN
          sgn_d   = sgn;
          sa_d    = neg_a;
          sb_d    = neg_b;
`endif
        end
      end
      LOAD: begin
        cnt_d = CNT_W'(WIDTH);
        if (cmd_q == CMD_DIV && opd_q == '0) begin
          state_d    = DONE;
          done_d     = 1'b1;
          res_hi_d   = hi_q;
          res_lo_d   = '1;
          div_zero_d = 1'b1;
        end else begin
          state_d    = ITER;
          busy_d     = 1'b1;
          hi_d       = '0;
          div_zero_d = 1'b0;
        end
      end
      ITER: begin
        hi_d   = (cmd_q == CMD_MUL) ? mul_hi : div_hi;
        lo_d   = (cmd_q == CMD_MUL) ? mul_lo : div_lo;
        cnt_d  = cnt_q - 1'b1;
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          busy_d   = 1'b0;
          state_d  = DONE;
          done_d   = 1'b1;
          res_hi_d = hi_d;
          res_lo_d = lo_d;
`ifdef MULDIV_SIGNED_EN
          if (sgn_q) begin
            state_d  = FIXUP;
            done_d   = 1'b0;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
          end
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      FIXUP: begin
        state_d  = DONE;
        done_d   = 1'b1;
        res_hi_d = fix_hi;
        res_lo_d = fix_lo;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
`ifdef MULDIV_SIGNED_EN
      sgn_q      <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opd_q      <= opd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q      <= sgn_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign res_hi   = res_hi_q;
  assign res_lo   = res_lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq with a behavioural ALU on the alu_* ports.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, cmd, sgn;
  logic [15:0] op_a, op_b;
  logic        busy, done, div_zero, alu_s_inm, alu_carry;
  logic [15:0] res_hi, res_lo, alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Add carry is deliberately garbage so any use of it in the multiply path shows up.
  always_comb begin
    alu_y     = alu_a;
    alu_carry = 1'b0;
    case (alu_op)
      3'b010: begin alu_y = alu_a + alu_b; alu_carry = ^alu_y; end
      3'b011: begin alu_y = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'b110: alu_y = -alu_a;
      default: alu_y = alu_a;
    endcase
  end

  muldiv_seq #(.WIDTH(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmd       (cmd),
    .sgn       (sgn),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .div_zero  (div_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_s_inm (alu_s_inm),
    .alu_y     (alu_y),
    .alu_carry (alu_carry)
  );

  // Drives one request; lat = negedge count (from the start-sampling edge) at which done was seen, 0 on timeout.
  task automatic run_op(input logic c, input logic s, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt, output bit overlap);
    @(negedge clk);
    cmd = c; sgn = s; op_a = a; op_b = b; start = 1'b1;
    lat = 0; busy_cnt = 0; overlap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && done) overlap = 1'b1;
      if (done) begin lat = i; break; end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic push_exp(input logic [15:0] hi, input logic [15:0] lo, input logic dz, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; cmd = 1'b0; sgn = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, res_hi, res_lo, alu_a, alu_b, alu_op, alu_s_inm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b dz=%b hi=%h lo=%h alu_a=%h alu_b=%h op=%b s_inm=%b want all 0",
               busy, done, div_zero, res_hi, res_lo, alu_a, alu_b, alu_op, alu_s_inm);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops(input string name, input logic c, input logic s,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ehi, input logic [15:0] elo, input logic edz, input int elat);
    int lat, bc;
    bit ov;
    exp_t e;
    push_exp(ehi, elo, edz, elat);
    run_op(c, s, a, b, lat, bc, ov);
    e = sb.pop_front();
    checks++;
    if (res_hi !== e.hi || res_lo !== e.lo) begin
      errors++;
      $display("FAIL %s result got %h/%h want %h/%h", name, res_hi, res_lo, e.hi, e.lo);
    end
    checks++;
    if (div_zero !== e.dz) begin
      errors++;
      $display("FAIL %s div_zero got %b want %b", name, div_zero, e.dz);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
    end
    checks++;
    if (bc != e.lat - 1 || ov) begin
      errors++;
      $display("FAIL %s busy got %0d cycles overlap=%b want %0d cycles overlap=0", name, bc, ov, e.lat - 1);
    end
  endtask

  task automatic test_mul;
    test_ops("mul_ff_101",   1'b0, 1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 18);
    test_ops("mul_max",      1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 18);
    test_ops("mul_zero",     1'b0, 1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 18);
    test_ops("mul_mix",      1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 18);
  endtask

  task automatic test_div;
    test_ops("div_100_7",    1'b1, 1'b0, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 18);
    test_ops("div_rmsb",     1'b1, 1'b0, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 18);
    test_ops("div_by_one",   1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 18);
    test_ops("div_small",    1'b1, 1'b0, 16'h0005, 16'hFFFF, 16'h0005, 16'h0000, 1'b0, 18);
    test_ops("div_zero",     1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 2);
    test_ops("div_after_dz", 1'b1, 1'b0, 16'd50,   16'd8,    16'h0002, 16'h0006, 1'b0, 18);
  endtask

  task automatic test_sgn;
`ifdef MULDIV_SIGNED_EN
    test_ops("smul_m7_3",    1'b0, 1'b1, 16'hFFF9, 16'h0003, 16'hFFFF, 16'hFFEB, 1'b0, 19);
    test_ops("sdiv_m7_2",    1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 19);
    test_ops("sdiv_min",     1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 19);
    test_ops("sdiv_zero",    1'b1, 1'b1, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1, 2);
`else
    test_ops("sgn_ignored",  1'b0, 1'b1, 16'hFFF9, 16'h0003, 16'h0002, 16'hFFEB, 1'b0, 18);
`endif
  endtask

  task automatic test_ignore_start;
    int lat = 0;
    int extra = 0;
    exp_t e;
    push_exp(16'h0000, 16'hFFFF, 1'b0, 18);
    @(negedge clk);
    cmd = 1'b0; sgn = 1'b0; op_a = 16'h00FF; op_b = 16'h0101; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 1 || i == 8 || i == 17);
      if (start) begin cmd = 1'b1; op_a = 16'h0009; op_b = 16'h0003; end
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (res_hi !== e.hi || res_lo !== e.lo || lat != e.lat) begin
      errors++;
      $display("FAIL ignore_start got %h/%h lat %0d want %h/%h lat %0d", res_hi, res_lo, lat, e.hi, e.lo, e.lat);
    end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_queue got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    @(negedge clk);
    cmd = 1'b0; sgn = 1'b0; op_a = 16'h00FF; op_b = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, res_hi, res_lo, alu_a, alu_b, alu_op, alu_s_inm} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h alu_a=%h alu_b=%h op=%b want all 0",
               busy, done, res_hi, res_lo, alu_a, alu_b, alu_op);
    end
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort got %0d busy/done cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    test_ops("b2b_div", 1'b1, 1'b0, 16'd1000, 16'd33,   16'h000A, 16'h001E, 1'b0, 18);
    test_ops("b2b_mul", 1'b0, 1'b0, 16'd300,  16'd300,  16'h0001, 16'h5F90, 1'b0, 18);
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_sgn;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
